// File: rtl/ks_multivoice_delay.sv
// ks_multivoice_delay
//   Multi-voice Karplus-Strong plucked-string engine. One sequencer walks the
//   voices once per audio sample_tick (RD -> LAT -> WR per voice). All voices
//   share one RAM. Each voice owns a circular delay line in that RAM, plus an
//   averaging low-pass filter with decay in the feedback path. A rising edge
//   on trig[v] loads a noise burst of Le samples into the string of voice v.
//
// Ports
//   clk          system clock
//   reset_n      synchronous, active-low reset
//   sample_tick  1-cycle strobe at the audio sample rate
//   trig         per-voice excite request (level; rising edge is detected)
//   length       per-voice delay length L, voice v at [v*ADDR_W +: ADDR_W]
//   noise_in     signed excitation sample, used in the WR cycle
//   out_valid    1-cycle pulse per voice per tick
//   out_voice    voice index belonging to out_data
//   out_data     delay-line sample read for out_voice
//   busy         high whenever the sequencer is not IDLE
//   overrun      sticky: a tick arrived while RD/LAT/WR was in progress
module ks_multivoice_delay #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int VOICES      = 4,
  parameter int DECAY_SHIFT = 8,
  localparam int VW         = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_tick,
  input  logic [VOICES-1:0]        trig,
  input  logic [VOICES*ADDR_W-1:0] length,
  input  logic [DATA_W-1:0]        noise_in,
  output logic                     out_valid,
  output logic [VW-1:0]            out_voice,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy,
  output logic                     overrun
);

  localparam int VB    = $clog2(VOICES);
  localparam int AW    = ADDR_W + VB;
  localparam int DEPTH = VOICES << ADDR_W;
  localparam int LW    = ADDR_W + 1;
  localparam logic [VW-1:0] LAST_V = VW'(VOICES - 1);
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, RD, LAT, WR} state_t;

  state_t                   state_reg;
  logic [VW-1:0]            voice_reg;
  logic [AW-1:0]            clr_addr_reg;
  logic [LW-1:0]            le_reg;
  logic [ADDR_W-1:0]        ptr_reg    [VOICES];
  logic [LW-1:0]            burst_reg  [VOICES];
  logic signed [DATA_W-1:0] x_prev_reg [VOICES];
  logic [VOICES-1:0]        trig_reg;
  logic [VOICES-1:0]        pending_reg;
  logic [VOICES-1:0]        pending_next;

  // Shared delay-line storage, sync read with one cycle of latency.
  logic [DATA_W-1:0]        ram [DEPTH];
  logic [DATA_W-1:0]        ram_q_reg;
  logic                     ram_we;
  logic                     ram_re;
  logic [AW-1:0]            ram_waddr;
  logic [DATA_W-1:0]        ram_wdata;
  logic [AW-1:0]            voice_addr;

  // Current voice datapath
  logic [ADDR_W-1:0]        l_cur;
  logic [LW-1:0]            le_cur;
  logic [LW-1:0]            ptr_inc;
  logic [ADDR_W-1:0]        ptr_wrap;
  logic                     burst_active;
  logic signed [DATA_W-1:0] x_cur;
  logic signed [DATA_W-1:0] xp_cur;
  logic signed [DATA_W:0]   sum_val;
  logic signed [DATA_W:0]   avg_val;
  logic signed [DATA_W-1:0] y_val;

  assign busy = (state_reg != IDLE);

  // Read and write of one voice use the same address {v, ptr[v]}. ptr only
  // moves at the end of WR, so the delay is exactly Le ticks. With a single
  // voice the voice bit is dropped by the truncating cast.
  assign voice_addr = AW'({voice_reg, ptr_reg[voice_reg]});

  // Lengths below 2 are raised to 2, so the ring always has at least two taps.
  assign l_cur  = length[int'(voice_reg)*ADDR_W +: ADDR_W];
  assign le_cur = (l_cur < ADDR_W'(2)) ? LW'(2) : {1'b0, l_cur};

  // Comparing against Le (and not testing ptr == Le-1) also covers a length
  // that shrank below the current ptr: such a ptr wraps to 0 on the next step.
  assign ptr_inc  = {1'b0, ptr_reg[voice_reg]} + LW'(1);
  assign ptr_wrap = (ptr_inc >= le_reg) ? '0 : ptr_inc[ADDR_W-1:0];

  assign burst_active = (burst_reg[voice_reg] != '0);

  // Filter: average of the current and previous taps, then decay. The sum
  // uses one guard bit. Halving it brings it back into DATA_W range, so the
  // truncating cast cannot overflow.
  assign x_cur   = ram_q_reg;
  assign xp_cur  = x_prev_reg[voice_reg];
  assign sum_val = {x_cur[DATA_W-1], x_cur} + {xp_cur[DATA_W-1], xp_cur};
  assign avg_val = sum_val >>> 1;
  assign y_val   = DATA_W'(avg_val - (avg_val >>> DECAY_SHIFT));

  // RAM port control. Writes are gated by reset_n, so a reset that lands in
  // WR aborts the voice without writing.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = voice_addr;
    ram_wdata = '0;
    if (reset_n) begin
      case (state_reg)
        CLEAR: begin
          ram_we    = 1'b1;
          ram_waddr = clr_addr_reg;
        end
        RD: ram_re = 1'b1;
        WR: begin
          ram_we    = 1'b1;
          ram_wdata = burst_active ? noise_in : y_val;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (ram_re) ram_q_reg <= ram[voice_addr];
  end

  // The edge detector runs every clock. A new edge takes priority over the
  // RD-time clear, so an edge in the same cycle as RD(v) is not lost.
  always_ff @(posedge clk) begin
    trig_reg <= trig;
  end

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_pending
      always_comb begin
        pending_next[gi] = pending_reg[gi];
        if (state_reg == RD && voice_reg == VW'(gi)) pending_next[gi] = 1'b0;
        if (trig[gi] && !trig_reg[gi])               pending_next[gi] = 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) pending_reg <= '0;
    else          pending_reg <= pending_next;
  end

  // Sequencer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= CLEAR;
      voice_reg    <= '0;
      clr_addr_reg <= '0;
      le_reg       <= '0;
      out_valid    <= 1'b0;
      out_voice    <= '0;
      out_data     <= '0;
      overrun      <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        ptr_reg[i]    <= '0;
        burst_reg[i]  <= '0;
        x_prev_reg[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (sample_tick && (state_reg == RD || state_reg == LAT || state_reg == WR))
        overrun <= 1'b1;
      case (state_reg)
        CLEAR: begin
          clr_addr_reg <= clr_addr_reg + AW'(1);
          if (clr_addr_reg == LAST_A) state_reg <= IDLE;
        end
        IDLE: begin
          if (sample_tick) begin
            voice_reg <= '0;
            state_reg <= RD;
          end
        end
        RD: begin
          le_reg <= le_cur;
          if (pending_reg[voice_reg]) burst_reg[voice_reg] <= le_cur;
          state_reg <= LAT;
        end
        LAT: state_reg <= WR;
        WR: begin
          out_valid  <= 1'b1;
          out_voice  <= voice_reg;
          out_data   <= ram_q_reg;
          if (burst_active) burst_reg[voice_reg] <= burst_reg[voice_reg] - LW'(1);
          x_prev_reg[voice_reg] <= x_cur;
          ptr_reg[voice_reg]    <= ptr_wrap;
          if (voice_reg == LAST_V) begin
            state_reg <= IDLE;
          end else begin
            voice_reg <= voice_reg + VW'(1);
            state_reg <= RD;
          end
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

endmodule
